// File: rtl/wiphy_pkg.sv
// Shared definitions for the baseband PHY shell: register map, control/IRQ bit
// positions, AXI response codes and the packed I/Q sample type.
package wiphy_pkg;

   localparam logic [15:0] REG_ID       = 16'h0000;
   localparam logic [15:0] REG_CTRL     = 16'h0004;
   localparam logic [15:0] REG_STATUS   = 16'h0008;
   localparam logic [15:0] REG_IRQ_EN   = 16'h000C;
   localparam logic [15:0] REG_IRQ_STAT = 16'h0010;
   localparam logic [15:0] REG_TX_COUNT = 16'h0014;
   localparam logic [15:0] REG_RX_COUNT = 16'h0018;

   localparam int CTRL_TX_EN    = 0;
   localparam int CTRL_RX_EN    = 1;
   localparam int CTRL_LOOPBACK = 2;
   localparam int CTRL_RX_CHAN  = 3;
   localparam int CTRL_TX_DUP   = 4;

   localparam int IRQ_RX_OVF = 0;
   localparam int IRQ_TX_UDF = 1;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef struct packed {
      logic [15:0] q;
      logic [15:0] i;
   } sample_t;

endpackage

// File: rtl/wiphy_axil_regs.sv
// AXI4-Lite slave and register file: CTRL/IRQ configuration, W1C interrupt
// status, sample counters and the registered interrupt line.
module wiphy_axil_regs
   import wiphy_pkg::*;
#(
   parameter logic [31:0] ID_VALUE   = 32'h5749_5048,
   parameter int unsigned ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  s_axi_awvalid,
   input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
   input  logic [2:0]            s_axi_awprot,
   output logic                  s_axi_awready,
   input  logic                  s_axi_wvalid,
   input  logic [31:0]           s_axi_wdata,
   input  logic [3:0]            s_axi_wstrb,
   output logic                  s_axi_wready,
   output logic                  s_axi_bvalid,
   output logic [1:0]            s_axi_bresp,
   input  logic                  s_axi_bready,
   input  logic                  s_axi_arvalid,
   input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
   input  logic [2:0]            s_axi_arprot,
   output logic                  s_axi_arready,
   output logic                  s_axi_rvalid,
   output logic [31:0]           s_axi_rdata,
   output logic [1:0]            s_axi_rresp,
   input  logic                  s_axi_rready,
   input  logic                  tx_active,
   input  logic                  tx_inc,
   input  logic                  rx_inc,
   input  logic [1:0]            irq_set,
   output logic [4:0]            ctrl,
   output logic                  irq
);

   logic [4:0]            ctrl_q, ctrl_d;
   logic [1:0]            irq_en_q, irq_en_d;
   logic [1:0]            irq_stat_q, irq_stat_d;
   logic [31:0]           tx_cnt_q, tx_cnt_d;
   logic [31:0]           rx_cnt_q, rx_cnt_d;
   logic                  bvalid_q, bvalid_d;
   logic                  rvalid_q, rvalid_d;
   logic [31:0]           rdata_q, rdata_d;
   logic [1:0]            rresp_q, rresp_d;
   logic                  irq_q, irq_d;
   logic                  aw_fire, ar_fire;
   logic [ADDR_WIDTH-1:0] wa, ra;
   logic                  unused_bits;

   assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0],
                          s_axi_wdata[31:5], s_axi_wstrb[3:1]};

   assign wa = {s_axi_awaddr[ADDR_WIDTH-1:2], 2'b00};
   assign ra = {s_axi_araddr[ADDR_WIDTH-1:2], 2'b00};

   always_comb begin
      aw_fire    = s_axi_awvalid & s_axi_wvalid & ~bvalid_q;
      ar_fire    = s_axi_arvalid & ~rvalid_q;
      ctrl_d     = ctrl_q;
      irq_en_d   = irq_en_q;
      irq_stat_d = irq_stat_q;
      tx_cnt_d   = tx_cnt_q + 32'(tx_inc);
      rx_cnt_d   = rx_cnt_q + 32'(rx_inc);
      if (aw_fire) begin
         if (wa == ADDR_WIDTH'(REG_CTRL) && s_axi_wstrb[0])
            ctrl_d = s_axi_wdata[4:0];
         if (wa == ADDR_WIDTH'(REG_IRQ_EN) && s_axi_wstrb[0])
            irq_en_d = s_axi_wdata[1:0];
         if (wa == ADDR_WIDTH'(REG_IRQ_STAT) && s_axi_wstrb[0])
            irq_stat_d = irq_stat_q & ~s_axi_wdata[1:0];
         if (wa == ADDR_WIDTH'(REG_TX_COUNT))
            tx_cnt_d = '0;
         if (wa == ADDR_WIDTH'(REG_RX_COUNT))
            rx_cnt_d = '0;
      end
      // a set event in the same cycle as a W1C clear keeps the bit set
      irq_stat_d = irq_stat_d | irq_set;

      bvalid_d = aw_fire | (bvalid_q & ~s_axi_bready);
      rvalid_d = ar_fire | (rvalid_q & ~s_axi_rready);
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      if (ar_fire) begin
         rresp_d = RESP_OKAY;
         case (ra)
            ADDR_WIDTH'(REG_ID):       rdata_d = ID_VALUE;
            ADDR_WIDTH'(REG_CTRL):     rdata_d = {27'b0, ctrl_q};
            ADDR_WIDTH'(REG_STATUS):   rdata_d = {30'b0, ctrl_q[CTRL_RX_EN], tx_active};
            ADDR_WIDTH'(REG_IRQ_EN):   rdata_d = {30'b0, irq_en_q};
            ADDR_WIDTH'(REG_IRQ_STAT): rdata_d = {30'b0, irq_stat_q};
            ADDR_WIDTH'(REG_TX_COUNT): rdata_d = tx_cnt_q;
            ADDR_WIDTH'(REG_RX_COUNT): rdata_d = rx_cnt_q;
            default: begin
               rdata_d = '0;
               rresp_d = RESP_SLVERR;
            end
         endcase
      end
      irq_d = |(irq_stat_q & irq_en_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q     <= '0;
         irq_en_q   <= '0;
         irq_stat_q <= '0;
         tx_cnt_q   <= '0;
         rx_cnt_q   <= '0;
         bvalid_q   <= 1'b0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= RESP_OKAY;
         irq_q      <= 1'b0;
      end else begin
         ctrl_q     <= ctrl_d;
         irq_en_q   <= irq_en_d;
         irq_stat_q <= irq_stat_d;
         tx_cnt_q   <= tx_cnt_d;
         rx_cnt_q   <= rx_cnt_d;
         bvalid_q   <= bvalid_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
         irq_q      <= irq_d;
      end
   end

   assign s_axi_awready = aw_fire;
   assign s_axi_wready  = aw_fire;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = RESP_OKAY;
   assign s_axi_arready = ~rvalid_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = rresp_q;
   assign ctrl          = ctrl_q;
   assign irq           = irq_q;

endmodule

// File: rtl/wiphy_core.sv
// Baseband PHY shell: TX stream to DAC register stage, ADC (or DAC loopback)
// to RX stream register stage, with control/status via wiphy_axil_regs.
module wiphy_core
   import wiphy_pkg::*;
#(
   parameter logic [31:0] ID_VALUE   = 32'h5749_5048,
   parameter int unsigned ADDR_WIDTH = 16
) (
   input  logic                  s_axi_aclk,
   input  logic                  s_axi_aresetn,
   input  logic                  s_axi_awvalid,
   input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
   input  logic [2:0]            s_axi_awprot,
   output logic                  s_axi_awready,
   input  logic                  s_axi_wvalid,
   input  logic [31:0]           s_axi_wdata,
   input  logic [3:0]            s_axi_wstrb,
   output logic                  s_axi_wready,
   output logic                  s_axi_bvalid,
   output logic [1:0]            s_axi_bresp,
   input  logic                  s_axi_bready,
   input  logic                  s_axi_arvalid,
   input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
   input  logic [2:0]            s_axi_arprot,
   output logic                  s_axi_arready,
   output logic                  s_axi_rvalid,
   output logic [31:0]           s_axi_rdata,
   output logic [1:0]            s_axi_rresp,
   input  logic                  s_axi_rready,
   input  logic                  s_axis_tvalid,
   input  logic [31:0]           s_axis_tdata,
   output logic                  s_axis_tready,
   output logic                  m_axis_tvalid,
   output logic [31:0]           m_axis_tdata,
   input  logic                  m_axis_tready,
   output logic                  dac_valid,
   input  logic                  dac_ready,
   output logic [15:0]           dac_data_i0,
   output logic [15:0]           dac_data_q0,
   output logic [15:0]           dac_data_i1,
   output logic [15:0]           dac_data_q1,
   input  logic                  adc_valid,
   input  logic [15:0]           adc_data_i0,
   input  logic [15:0]           adc_data_q0,
   input  logic [15:0]           adc_data_i1,
   input  logic [15:0]           adc_data_q1,
   output logic                  irq
);

   logic [4:0] ctrl;
   logic [1:0] irq_set;
   logic       tx_en, rx_en, loopback, rx_chan, tx_dup;
   logic       tx_fire, dac_hs, src_valid, rx_take, rx_load;
   sample_t    tx_s, src;
   sample_t    dac0_q, dac0_d, dac1_q, dac1_d, m_data_q, m_data_d;
   logic       dac_valid_q, dac_valid_d;
   logic       tx_active_q, tx_active_d;
   logic       m_valid_q, m_valid_d;

   assign tx_s     = s_axis_tdata;
   assign tx_en    = ctrl[CTRL_TX_EN];
   assign rx_en    = ctrl[CTRL_RX_EN];
   assign loopback = ctrl[CTRL_LOOPBACK];
   assign rx_chan  = ctrl[CTRL_RX_CHAN];
   assign tx_dup   = ctrl[CTRL_TX_DUP];

   assign s_axis_tready = tx_en & (~dac_valid_q | dac_ready);

   always_comb begin
      tx_fire     = s_axis_tvalid & s_axis_tready;
      dac_hs      = dac_valid_q & dac_ready;
      dac_valid_d = tx_fire | (dac_valid_q & ~dac_ready);
      dac0_d      = tx_fire ? tx_s : dac0_q;
      dac1_d      = dac1_q;
      if (tx_fire)
         dac1_d = tx_dup ? tx_s : '0;
      tx_active_d = tx_en & (tx_active_q | tx_fire);

      // loopback observes the DAC handshake on channel 0 only
      src_valid = loopback ? dac_hs : adc_valid;
      if (loopback)
         src = dac0_q;
      else if (rx_chan)
         src = '{q: adc_data_q1, i: adc_data_i1};
      else
         src = '{q: adc_data_q0, i: adc_data_i0};

      rx_take   = rx_en & src_valid;
      rx_load   = rx_take & (~m_valid_q | m_axis_tready);
      m_valid_d = rx_load | (m_valid_q & ~m_axis_tready);
      m_data_d  = rx_load ? src : m_data_q;

      irq_set             = '0;
      irq_set[IRQ_RX_OVF] = rx_take & ~rx_load;
      irq_set[IRQ_TX_UDF] = tx_active_q & dac_ready & ~dac_valid_q;
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         dac0_q      <= '0;
         dac1_q      <= '0;
         dac_valid_q <= 1'b0;
         tx_active_q <= 1'b0;
         m_valid_q   <= 1'b0;
         m_data_q    <= '0;
      end else begin
         dac0_q      <= dac0_d;
         dac1_q      <= dac1_d;
         dac_valid_q <= dac_valid_d;
         tx_active_q <= tx_active_d;
         m_valid_q   <= m_valid_d;
         m_data_q    <= m_data_d;
      end
   end

   wiphy_axil_regs #(
      .ID_VALUE   (ID_VALUE),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_regs (
      .clk           (s_axi_aclk),
      .rst_n         (s_axi_aresetn),
      .s_axi_awvalid (s_axi_awvalid),
      .s_axi_awaddr  (s_axi_awaddr),
      .s_axi_awprot  (s_axi_awprot),
      .s_axi_awready (s_axi_awready),
      .s_axi_wvalid  (s_axi_wvalid),
      .s_axi_wdata   (s_axi_wdata),
      .s_axi_wstrb   (s_axi_wstrb),
      .s_axi_wready  (s_axi_wready),
      .s_axi_bvalid  (s_axi_bvalid),
      .s_axi_bresp   (s_axi_bresp),
      .s_axi_bready  (s_axi_bready),
      .s_axi_arvalid (s_axi_arvalid),
      .s_axi_araddr  (s_axi_araddr),
      .s_axi_arprot  (s_axi_arprot),
      .s_axi_arready (s_axi_arready),
      .s_axi_rvalid  (s_axi_rvalid),
      .s_axi_rdata   (s_axi_rdata),
      .s_axi_rresp   (s_axi_rresp),
      .s_axi_rready  (s_axi_rready),
      .tx_active     (tx_active_q),
      .tx_inc        (dac_hs),
      .rx_inc        (rx_load),
      .irq_set       (irq_set),
      .ctrl          (ctrl),
      .irq           (irq)
   );

   assign dac_valid     = dac_valid_q;
   assign dac_data_i0   = dac0_q.i;
   assign dac_data_q0   = dac0_q.q;
   assign dac_data_i1   = dac1_q.i;
   assign dac_data_q1   = dac1_q.q;
   assign m_axis_tvalid = m_valid_q;
   assign m_axis_tdata  = m_data_q;

endmodule

// File: tb/tb_wiphy_core.sv
// Directed bench for wiphy_core: register access, TX/RX datapaths, loopback and
// interrupt behaviour against hand-computed values.
module tb_wiphy_core;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        awvalid, wvalid, bvalid, bready, arvalid, rvalid, rready;
   logic        awready, wready, arready;
   logic [15:0] awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;
   logic        s_tvalid, s_tready, m_tvalid, m_tready;
   logic [31:0] s_tdata, m_tdata;
   logic        dac_valid, dac_ready, adc_valid, irq;
   logic [15:0] dac_i0, dac_q0, dac_i1, dac_q1;
   logic [15:0] adc_i0, adc_q0, adc_i1, adc_q1;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] rd_val;
   logic [1:0]  rd_resp;

   always #5 clk = ~clk;

   wiphy_core dut (
      .s_axi_aclk    (clk),
      .s_axi_aresetn (rst_n),
      .s_axi_awvalid (awvalid),
      .s_axi_awaddr  (awaddr),
      .s_axi_awprot  (awprot),
      .s_axi_awready (awready),
      .s_axi_wvalid  (wvalid),
      .s_axi_wdata   (wdata),
      .s_axi_wstrb   (wstrb),
      .s_axi_wready  (wready),
      .s_axi_bvalid  (bvalid),
      .s_axi_bresp   (bresp),
      .s_axi_bready  (bready),
      .s_axi_arvalid (arvalid),
      .s_axi_araddr  (araddr),
      .s_axi_arprot  (arprot),
      .s_axi_arready (arready),
      .s_axi_rvalid  (rvalid),
      .s_axi_rdata   (rdata),
      .s_axi_rresp   (rresp),
      .s_axi_rready  (rready),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tdata  (s_tdata),
      .s_axis_tready (s_tready),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tdata  (m_tdata),
      .m_axis_tready (m_tready),
      .dac_valid     (dac_valid),
      .dac_ready     (dac_ready),
      .dac_data_i0   (dac_i0),
      .dac_data_q0   (dac_q0),
      .dac_data_i1   (dac_i1),
      .dac_data_q1   (dac_q1),
      .adc_valid     (adc_valid),
      .adc_data_i0   (adc_i0),
      .adc_data_q0   (adc_q0),
      .adc_data_i1   (adc_i1),
      .adc_data_q1   (adc_q1),
      .irq           (irq)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic axi_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb);
      bit seen;
      awvalid = 1'b1; wvalid = 1'b1; awaddr = addr; wdata = data; wstrb = strb;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         seen = awready & wready;
      end
      if (!seen) chk("aw_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         seen = bvalid;
      end
      if (!seen) chk("b_timeout", 32'd0, 32'd1);
      else chk("bresp", {30'b0, bresp}, 32'd0);
   endtask

   task automatic axi_read(input logic [15:0] addr, output logic [31:0] data, output logic [1:0] resp);
      bit seen;
      arvalid = 1'b1; araddr = addr;
      data = '0; resp = '0;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         seen = arready;
      end
      if (!seen) chk("ar_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      arvalid = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         seen = rvalid;
      end
      if (!seen) chk("r_timeout", 32'd0, 32'd1);
      data = rdata; resp = rresp;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n = 1'b0;
      awvalid = 0; wvalid = 0; arvalid = 0; awaddr = 0; araddr = 0; awprot = 3'd5; arprot = 3'd5;
      wdata = 0; wstrb = 0; bready = 1; rready = 1;
      s_tvalid = 0; s_tdata = 0; m_tready = 0; dac_ready = 0; adc_valid = 0;
      adc_i0 = 0; adc_q0 = 0; adc_i1 = 0; adc_q1 = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outs", {26'b0, dac_valid, m_tvalid, irq, s_tready, bvalid, rvalid}, 32'd0);
      chk("reset_data", {dac_i0, m_tdata[15:0]}, 32'd0);
      rst_n = 1'b1;
      step();

      axi_read(16'h0000, rd_val, rd_resp);
      chk("id_data", rd_val, 32'h5749_5048);
      chk("id_resp", {30'b0, rd_resp}, 32'd0);
      axi_read(16'h0040, rd_val, rd_resp);
      chk("unmapped_data", rd_val, 32'd0);
      chk("unmapped_resp", {30'b0, rd_resp}, 32'd2);

      axi_write(16'h0004, 32'h0000_0011, 4'h1);
      axi_read(16'h0006, rd_val, rd_resp);
      chk("ctrl_rb", rd_val, 32'h11);
      axi_write(16'h0004, 32'hFFFF_FF00, 4'h2);
      axi_read(16'h0004, rd_val, rd_resp);
      chk("ctrl_strb", rd_val, 32'h11);

      // TX with duplication onto channel 1
      step();
      dac_ready = 1'b1; s_tvalid = 1'b1; s_tdata = 32'h1234_ABCD;
      @(negedge clk);
      chk("tx_tready", {31'b0, s_tready}, 32'd1);
      step();
      s_tvalid = 1'b0;
      chk("tx_dac_valid", {31'b0, dac_valid}, 32'd1);
      chk("tx_ch0", {dac_q0, dac_i0}, 32'h1234_ABCD);
      chk("tx_ch1", {dac_q1, dac_i1}, 32'h1234_ABCD);
      step();
      chk("tx_consumed", {31'b0, dac_valid}, 32'd0);
      step();
      dac_ready = 1'b0;
      axi_read(16'h0014, rd_val, rd_resp);
      chk("tx_count", rd_val, 32'd1);
      axi_read(16'h0010, rd_val, rd_resp);
      chk("tx_underflow", rd_val, 32'h2);
      axi_read(16'h0008, rd_val, rd_resp);
      chk("status_tx", rd_val, 32'h1);

      axi_write(16'h0004, 32'h0000_000A, 4'hF);
      axi_write(16'h0010, 32'h0000_0003, 4'hF);
      axi_read(16'h0010, rd_val, rd_resp);
      chk("irq_stat_w1c", rd_val, 32'h0);
      axi_read(16'h0008, rd_val, rd_resp);
      chk("status_rx", rd_val, 32'h2);
      axi_write(16'h0014, 32'h0000_0005, 4'h0);
      axi_read(16'h0014, rd_val, rd_resp);
      chk("tx_count_clr", rd_val, 32'd0);

      // RX from ADC channel 1
      step();
      m_tready = 1'b1; adc_valid = 1'b1;
      adc_i0 = 16'h1111; adc_q0 = 16'h2222; adc_i1 = 16'h0005; adc_q1 = 16'hFFFB;
      step();
      adc_valid = 1'b0;
      chk("rx_valid", {31'b0, m_tvalid}, 32'd1);
      chk("rx_data", m_tdata, 32'hFFFB_0005);
      step();
      chk("rx_drained", {31'b0, m_tvalid}, 32'd0);
      axi_read(16'h0018, rd_val, rd_resp);
      chk("rx_count", rd_val, 32'd1);

      // overflow: second sample dropped while the first is held
      m_tready = 1'b0; adc_valid = 1'b1; adc_i1 = 16'h0001; adc_q1 = 16'h0002;
      step();
      adc_i1 = 16'h0003; adc_q1 = 16'h0004;
      step();
      adc_valid = 1'b0;
      chk("ovf_held", m_tdata, 32'h0002_0001);
      axi_read(16'h0010, rd_val, rd_resp);
      chk("ovf_stat", rd_val, 32'h1);
      chk("irq_masked", {31'b0, irq}, 32'd0);
      axi_write(16'h000C, 32'h0000_0001, 4'hF);
      step(); step();
      chk("irq_set", {31'b0, irq}, 32'd1);
      axi_write(16'h0010, 32'h0000_0001, 4'hF);
      step(); step();
      chk("irq_clr", {31'b0, irq}, 32'd0);
      axi_write(16'h0004, 32'h0000_0008, 4'hF);
      chk("rx_off_keep", {m_tvalid, m_tdata[30:0]}, 32'h8002_0001);
      m_tready = 1'b1;
      step();
      chk("rx_off_drain", {31'b0, m_tvalid}, 32'd0);

      // loopback through the DAC handshake
      axi_write(16'h0004, 32'h0000_0007, 4'hF);
      step();
      dac_ready = 1'b1; s_tvalid = 1'b1; s_tdata = 32'h0007_0003;
      step();
      s_tvalid = 1'b0;
      step();
      chk("lb_valid", {31'b0, m_tvalid}, 32'd1);
      chk("lb_data", m_tdata, 32'h0007_0003);
      chk("lb_nodup", {dac_q1, dac_i1}, 32'd0);
      dac_ready = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/wiphy_core.md
Name: wiphy_core

Overview:
Baseband PHY shell between the host and the RF transceiver data port. It has three parts:
- an AXI4-Lite control/status register file;
- a TX path from an AXI4-Stream sample input to the DAC interface;
- an RX path from the ADC interface to an AXI4-Stream sample output, plus a level interrupt.

Samples are 32-bit {Q[31:16], I[15:0]}, 16-bit two's complement. Everything runs in one clock domain.

Parameters:
- ID_VALUE, 32'h5749_5048, constant returned by the ID register.
- ADDR_WIDTH, 16, AXI4-Lite address width.

Ports:
- s_axi_aclk  in  1  sole clock
- s_axi_aresetn  in  1  asynchronous, active-low reset
- s_axi_aw{valid,addr[15:0],prot[2:0]} in, s_axi_awready out  write address
- s_axi_w{valid,data[31:0],strb[3:0]} in, s_axi_wready out  write data
- s_axi_bvalid out, s_axi_bresp out [1:0], s_axi_bready in  write response
- s_axi_ar{valid,addr[15:0],prot[2:0]} in, s_axi_arready out  read address
- s_axi_rvalid out, s_axi_rdata out [31:0], s_axi_rresp out [1:0], s_axi_rready in  read data
- s_axis_tvalid in, s_axis_tdata in [31:0], s_axis_tready out  TX samples
- m_axis_tvalid out, m_axis_tdata out [31:0], m_axis_tready in  RX samples
- dac_valid out, dac_ready in, dac_data_{i0,q0,i1,q1} out [15:0]  DAC port
- adc_valid in, adc_data_{i0,q0,i1,q1} in [15:0]  ADC port, no backpressure
- irq out 1  level interrupt

Behaviour:
- Reset: every output and register is 0, except that ready signals follow their own equations.
- AXI-Lite write:
  - AW and W are accepted together (awready = wready = 1 for one cycle) when both are valid and no B is pending.
  - bvalid is asserted the next cycle and held until bready.
  - bresp is always OKAY.
  - wstrb is honoured per byte on RW registers; prot is ignored.
- AXI-Lite read:
  - arready = ~rvalid.
  - rdata and rresp are registered: rvalid rises the cycle after the AR handshake and holds until rready.
  - Unmapped addresses read 0 with rresp = SLVERR (2'b10); writes to them are ignored with OKAY.
  - Address bits [1:0] are ignored.
- Register map:
  - 0x00 ID, RO, ID_VALUE.
  - 0x04 CTRL, RW: b0 tx_en, b1 rx_en, b2 loopback, b3 rx_chan, b4 tx_dup.
  - 0x08 STATUS, RO: b0 tx_active, b1 rx_active (= rx_en).
  - 0x0C IRQ_EN, RW, bits [1:0].
  - 0x10 IRQ_STAT, W1C: b0 rx_overflow, b1 tx_underflow.
  - 0x14 TX_COUNT and 0x18 RX_COUNT: 32-bit, wrap at 2^32; any write clears to 0.
- TX path:
  - Single register stage. s_axis_tready = tx_en & (~dac_valid | dac_ready).
  - On an s_axis handshake, dac_data_i0/q0 load I/Q and dac_valid = 1. Channel 1 gets the same I/Q if tx_dup, else 0.
  - dac_valid clears on dac_ready when no new beat arrives in that cycle.
  - TX_COUNT increments on each dac_valid & dac_ready.
  - tx_active sets on the first accepted beat and clears when tx_en = 0.
  - tx_underflow sets when tx_active & dac_ready & ~dac_valid.
  - Clearing tx_en mid-stream: a held DAC beat is still presented until it is consumed.
- RX path:
  - Source is the ADC, or the DAC handshake (channel 0) when loopback = 1.
  - A sample is taken when rx_en & source-valid. It packs {q,i} from channel rx_chan (loopback always uses channel 0).
  - Taking a sample loads m_axis_tdata and sets m_axis_tvalid, provided the output register is empty or being accepted in the same cycle. RX_COUNT increments.
  - If the output register holds an unaccepted beat, the new sample is dropped, the held beat is kept unchanged, and rx_overflow sets.
  - m_axis_tvalid clears on handshake when no new sample arrives.
  - Clearing rx_en does not drop a pending beat.
- Interrupt:
  - irq = |(IRQ_STAT & IRQ_EN), registered, so it lags by one cycle.
  - When a W1C write and a set event hit the same bit in the same cycle, the set wins.

Decomposition:
- Package wiphy_pkg holds:
  - register offset localparams;
  - CTRL/IRQ bit indices;
  - response codes (OKAY, SLVERR);
  - a packed sample_t {logic [15:0] q, i}.
- One natural sub-module, wiphy_axil_regs, containing the AXI-Lite slave and register file. The datapath stays in wiphy_core.

Test Plan:
- Reset, then read 0x00 -> rdata = 32'h57495048, rresp = 0. Read 0x40 -> rdata = 0, rresp = 2.
- Write CTRL = 0x11 with wstrb = 4'h1, read back -> 0x11. Write CTRL = 0xFFFFFF00 with wstrb = 4'h2 -> readback still 0x11.
- tx_en = 1, tx_dup = 1, dac_ready = 1, send 0x1234ABCD -> the next cycle dac_valid = 1, i0 = i1 = 0xABCD, q0 = q1 = 0x1234. TX_COUNT = 1. After the stream ends, IRQ_STAT b1 = 1.
- rx_en = 1, rx_chan = 1, m_axis_tready = 1, adc_valid pulse with i1 = 0x0005, q1 = 0xFFFB -> m_axis_tdata = 0xFFFB0005, RX_COUNT = 1.
- m_axis_tready = 0, two ADC samples -> first is held, second is dropped, rx_overflow = 1. With IRQ_EN = 1, irq = 1. Write 1 to IRQ_STAT -> irq = 0.
- loopback = 1, tx_en = rx_en = 1, send 0x00070003 -> m_axis_tdata = 0x00070003.
